// File: rtl/qqspi_cache_pkg.sv
// rtl/qqspi_cache_pkg.sv - shared types, widths and byte-merge helper for the qqspi read cache
package qqspi_cache_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM     = 2'd1,
        RELEASE = 2'd2
    } state_e;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                m[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/qqspi_cache_store.sv
// rtl/qqspi_cache_store.sv - tag/data/valid storage with async read and byte-enabled sync write
module qqspi_cache_store
    import qqspi_cache_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = ADDR_W - IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_vld_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic              wr_alloc_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [STRB_W-1:0] wr_strb_i,
    input  logic              clr_i
);

    logic [TAG_W-1:0]  tag_q  [ENTRIES];
    logic [DATA_W-1:0] data_q [ENTRIES];
    logic [ENTRIES-1:0] vld_q;

    // Clear wins over a same-cycle allocate so a flush never leaves a stale line valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else if (clr_i) begin
            vld_q <= '0;
        end else if (wr_en_i && wr_alloc_i) begin
            vld_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            if (wr_alloc_i) begin
                tag_q[wr_idx_i] <= wr_tag_i;
            end
            data_q[wr_idx_i] <= merge_bytes(data_q[wr_idx_i], wr_data_i, wr_strb_i);
        end
    end

    assign rd_vld_o  = vld_q[rd_idx_i];
    assign rd_tag_o  = tag_q[rd_idx_i];
    assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/qqspi_rd_cache.sv
// rtl/qqspi_rd_cache.sv - direct-mapped write-through word cache in front of the qqspi controller
module qqspi_rd_cache
    import qqspi_cache_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cache_en,
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              valid,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic              mem_valid,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int TAG_W = ADDR_W - IDX_W;

    state_e            state_q, state_d;
    logic              kill_q, kill_d;
    logic              whit_q, whit_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
    logic              mem_valid_q, mem_valid_d;

    logic              rd_vld;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              wr_alloc;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;

    logic req_is_read;
    logic mem_is_read;
    logic hit;
    logic accept;

    assign req_is_read = (wstrb == '0);
    assign mem_is_read = (mem_wstrb_q == '0);
    assign hit         = cache_en && rd_vld && (rd_tag == addr[ADDR_W-1:IDX_W]);
    // Blocking on ready_q keeps a request still held during its ready cycle from re-issuing.
    assign accept      = (state_q == IDLE) && valid && !ready_q;

    qqspi_cache_store #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_store (
        .clk        (clk),
        .reset      (reset),
        .rd_idx_i   (addr[IDX_W-1:0]),
        .rd_vld_o   (rd_vld),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_alloc_i (wr_alloc),
        .wr_idx_i   (mem_addr_q[IDX_W-1:0]),
        .wr_tag_i   (mem_addr_q[ADDR_W-1:IDX_W]),
        .wr_data_i  (wr_data),
        .wr_strb_i  (wr_strb),
        .clr_i      (flush)
    );

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        whit_d      = whit_q;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_valid_d = mem_valid_q;
        wr_en       = 1'b0;
        wr_alloc    = 1'b0;
        wr_data     = mem_rdata;
        wr_strb     = '1;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (accept) begin
                    if (req_is_read && hit) begin
                        rdata_d = rd_data;
                        ready_d = 1'b1;
                    end else begin
                        mem_addr_d  = addr;
                        mem_wdata_d = wdata;
                        mem_wstrb_d = wstrb;
                        mem_valid_d = 1'b1;
                        whit_d      = hit && !req_is_read;
                        state_d     = MEM;
                    end
                end
            end
            MEM: begin
                if (flush && mem_is_read) begin
                    kill_d = 1'b1;
                end
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = RELEASE;
                    if (mem_is_read) begin
                        rdata_d = mem_rdata;
                        // A flush landing on this very cycle must also stop the fill.
                        if (cache_en && !kill_q && !flush) begin
                            wr_en    = 1'b1;
                            wr_alloc = 1'b1;
                        end
                    end else if (whit_q && cache_en) begin
                        wr_en   = 1'b1;
                        wr_data = mem_wdata_q;
                        wr_strb = mem_wstrb_q;
                    end
                end
            end
            RELEASE: begin
                if (flush && mem_is_read) begin
                    kill_d = 1'b1;
                end
                if (!mem_ready) begin
                    ready_d = 1'b1;
                    kill_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            kill_q      <= 1'b0;
            whit_q      <= 1'b0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            whit_q      <= whit_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    assign ready     = ready_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_valid = mem_valid_q;

endmodule

// File: tb/tb_qqspi_rd_cache.sv
// tb/tb_qqspi_rd_cache.sv - table-driven scoreboard bench for qqspi_rd_cache
module tb_qqspi_rd_cache;

    localparam int LAT      = 2;
    localparam int MISS_LAT = 6;

    typedef struct {
        logic [22:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        en;
        logic [31:0] exp_rdata;
        int          exp_txn;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cache_en;
    logic        flush;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
    logic        ready;
    logic [31:0] rdata;
    logic [22:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_vec  = 0;
    int n_miss = 0;
    int txn_cnt = 0;
    int viol = 0;
    int lat_cnt;
    logic [3:0]  last_wstrb;
    logic [31:0] last_wdata;
    logic [31:0] mem_m [64];
    logic [31:0] tmp_w;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;

    vec_t exp_q[$];
    vec_t vecs[14];

    always #5 clk = ~clk;

    qqspi_rd_cache dut (
        .clk       (clk),
        .reset     (reset),
        .cache_en  (cache_en),
        .flush     (flush),
        .addr      (addr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .valid     (valid),
        .ready     (ready),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    // qqspi stand-in: ready LAT cycles after valid, dropped one cycle after valid falls.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ready <= 1'b0;
            lat_cnt   <= 0;
            mem_rdata <= '0;
        end else if (mem_valid && !mem_ready) begin
            if (lat_cnt == LAT - 1) begin
                lat_cnt    <= 0;
                mem_ready  <= 1'b1;
                txn_cnt    <= txn_cnt + 1;
                last_wstrb <= mem_wstrb;
                last_wdata <= mem_wdata;
                if (mem_wstrb == 4'b0000) begin
                    mem_rdata <= mem_m[mem_addr[5:0]];
                end else begin
                    tmp_w = mem_m[mem_addr[5:0]];
                    for (int b = 0; b < 4; b++) begin
                        if (mem_wstrb[b]) tmp_w[8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                    mem_m[mem_addr[5:0]] <= tmp_w;
                end
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else if (!mem_valid && mem_ready) begin
            mem_ready <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_v <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            if (mem_valid && !prev_v && mem_ready) viol <= viol + 1;
            if (!mem_valid && prev_v && !prev_r) viol <= viol + 1;
            prev_v <= mem_valid;
            prev_r <= mem_ready;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [22:0] a, input logic [31:0] wd, input logic [3:0] ws,
                                input logic en, input logic [31:0] er, input int et, input int el);
        vec_t v;
        v.addr = a; v.wdata = wd; v.wstrb = ws; v.en = en;
        v.exp_rdata = er; v.exp_txn = et; v.exp_lat = el;
        return v;
    endfunction

    // flush_mode: 0 none, 1 pulse while the transfer is in MEM, 2 pulse with the request
    task automatic run_req(input string name, input vec_t v, input int flush_mode);
        int   cyc;
        int   t0;
        bit   got;
        bit   flushed;
        vec_t e;
        cyc = 0; got = 0; flushed = 0;
        @(negedge clk);
        t0       = txn_cnt;
        addr     = v.addr;
        wdata    = v.wdata;
        wstrb    = v.wstrb;
        cache_en = v.en;
        valid    = 1'b1;
        if (flush_mode == 2) flush = 1'b1;
        exp_q.push_back(v);
        while (!got && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (flush) begin
                flush = 1'b0;
            end else if (flush_mode == 1 && !flushed && mem_valid) begin
                flush   = 1'b1;
                flushed = 1;
            end
            if (ready) got = 1;
        end
        e = exp_q.pop_front();
        if (!got) begin
            chk({name, " timeout"}, 32'd0, 32'd1);
        end else begin
            if (e.wstrb == 4'b0000) chk({name, " rdata"}, rdata, e.exp_rdata);
            chk({name, " txn"}, txn_cnt - t0, e.exp_txn);
            chk({name, " latency"}, cyc, e.exp_lat);
            if (e.wstrb != 4'b0000) begin
                chk({name, " mem_wstrb"}, {28'd0, last_wstrb}, {28'd0, e.wstrb});
                chk({name, " mem_wdata"}, last_wdata, e.wdata);
            end
        end
        @(negedge clk);
        valid = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_m[i] = 32'h0100_0000 * i + i;
        mem_m[6'h10] = 32'hDEADBEEF;
        mem_m[6'h11] = 32'h77778888;
        mem_m[6'h13] = 32'h99990000;
        mem_m[6'h18] = 32'h11112222;
        mem_m[6'h20] = 32'h33334444;
        mem_m[6'h30] = 32'h55556666;
    end

    initial begin
        reset = 1'b1; cache_en = 1'b1; flush = 1'b0;
        addr = '0; wdata = '0; wstrb = '0; valid = 1'b0;

        vecs[0]  = mk(23'h10, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1, MISS_LAT);
        vecs[1]  = mk(23'h10, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 0, 1);
        vecs[2]  = mk(23'h10, 32'h0000AA00, 4'h2, 1'b1, 32'h0,        1, MISS_LAT);
        vecs[3]  = mk(23'h10, 32'h0,        4'h0, 1'b1, 32'hDEADAAEF, 0, 1);
        vecs[4]  = mk(23'h20, 32'h12345678, 4'hF, 1'b1, 32'h0,        1, MISS_LAT);
        vecs[5]  = mk(23'h20, 32'h0,        4'h0, 1'b1, 32'h12345678, 1, MISS_LAT);
        vecs[6]  = mk(23'h18, 32'h0,        4'h0, 1'b1, 32'h11112222, 1, MISS_LAT);
        vecs[7]  = mk(23'h10, 32'h0,        4'h0, 1'b1, 32'hDEADAAEF, 1, MISS_LAT);
        vecs[8]  = mk(23'h10, 32'h0,        4'h0, 1'b1, 32'hDEADAAEF, 0, 1);
        vecs[9]  = mk(23'h10, 32'h0,        4'h0, 1'b0, 32'hDEADAAEF, 1, MISS_LAT);
        vecs[10] = mk(23'h10, 32'h000000CC, 4'h1, 1'b0, 32'h0,        1, MISS_LAT);
        vecs[11] = mk(23'h10, 32'h0,        4'h0, 1'b1, 32'hDEADAAEF, 0, 1);
        vecs[12] = mk(23'h11, 32'h0,        4'h0, 1'b1, 32'h77778888, 1, MISS_LAT);
        vecs[13] = mk(23'h11, 32'h0,        4'h0, 1'b1, 32'h77778888, 0, 1);

        repeat (3) @(negedge clk);
        chk("reset ready", {31'd0, ready}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("reset mem_bus", {mem_addr, 5'd0, mem_wstrb} ^ mem_wdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) run_req($sformatf("vec%0d", i), vecs[i], 0);

        run_req("flush_in_mem", mk(23'h30, 32'h0, 4'h0, 1'b1, 32'h55556666, 1, MISS_LAT), 1);
        run_req("killed_refetch", mk(23'h30, 32'h0, 4'h0, 1'b1, 32'h55556666, 1, MISS_LAT), 0);
        run_req("flushed_idx1", mk(23'h11, 32'h0, 4'h0, 1'b1, 32'h77778888, 1, MISS_LAT), 0);
        run_req("refill_10", mk(23'h10, 32'h0, 4'h0, 1'b1, 32'hDEADAACC, 1, MISS_LAT), 0);
        run_req("hit_10", mk(23'h10, 32'h0, 4'h0, 1'b1, 32'hDEADAACC, 0, 1), 0);

        begin
            int  cyc;
            bit  seen;
            cyc = 0; seen = 0;
            @(negedge clk);
            addr = 23'h13; wstrb = 4'h0; cache_en = 1'b1; valid = 1'b1;
            while (!seen && cyc < 20) begin
                @(posedge clk);
                #1;
                cyc++;
                if (mem_valid) seen = 1;
            end
            chk("rst_mid mem_valid seen", {31'd0, seen}, 32'd1);
            reset = 1'b1;
            #1;
            chk("rst_mid mem_valid", {31'd0, mem_valid}, 32'd0);
            chk("rst_mid ready", {31'd0, ready}, 32'd0);
            @(negedge clk);
            valid = 1'b0;
            repeat (2) @(negedge clk);
            reset = 1'b0;
        end

        run_req("post_rst_10", mk(23'h10, 32'h0, 4'h0, 1'b1, 32'hDEADAACC, 1, MISS_LAT), 0);
        run_req("flush_on_hit", mk(23'h10, 32'h0, 4'h0, 1'b1, 32'hDEADAACC, 0, 1), 2);
        run_req("after_flush_hit", mk(23'h10, 32'h0, 4'h0, 1'b1, 32'hDEADAACC, 1, MISS_LAT), 0);

        repeat (3) @(negedge clk);
        chk("handshake violations", viol, 32'd0);
        chk("scoreboard empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/qqspi_rd_cache.md
Name: qqspi_rd_cache

Overview:
- Small direct-mapped, write-through word cache between the CPU memory bus and the qqspi PSRAM/flash controller.
- Read hits return in one cycle, with no SPI traffic.
- Read misses and all writes are forwarded to qqspi using its valid/ready handshake. Read misses allocate; writes update the line only on a hit.
- Addresses are 8Mx32 word addresses, the same address space qqspi exposes.

Parameters:
- ENTRIES, 8: number of one-word lines; power of two, 2..64.
- IDX_W, $clog2(ENTRIES): index width, derived; do not override.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- cache_en  in  1  0 = bypass: every access is forwarded and nothing allocates.
- flush  in  1  single-cycle pulse; invalidates all lines.
- addr  in  23  upstream word address.
- wdata  in  32  upstream write data.
- wstrb  in  4  byte enables; 0 = read.
- valid  in  1  upstream request.
- ready  out  1  one-cycle completion pulse.
- rdata  out  32  read data; valid while ready=1.
- mem_addr  out  23  to qqspi addr.
- mem_wdata  out  32  to qqspi wdata.
- mem_wstrb  out  4  to qqspi wstrb.
- mem_valid  out  1  to qqspi valid.
- mem_ready  in  1  from qqspi ready.
- mem_rdata  in  32  from qqspi rdata.

Behaviour:
- Reset is asynchronous and acts immediately:
  - state=IDLE; all line valid bits cleared.
  - ready=0, rdata=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - Tag and data arrays need not be reset.
- Reset mid-transfer drops mem_valid at once. qqspi's own reset recovers the SPI side.
- Address split: idx=addr[IDX_W-1:0], tag=addr[22:IDX_W]. hit = cache_en & vld[idx] & (tag_q[idx]==tag).
- A request is accepted only in IDLE with valid=1 and ready=0. This prevents a request still asserted during the ready cycle from being re-issued. The requester drops valid, or presents a new request, the cycle after ready.
- States:
  - IDLE:
    - Read hit: rdata<=data[idx], ready<=1 next cycle, stay IDLE. Latency is 1 cycle.
    - Read miss or any write: register mem_addr, mem_wdata, mem_wstrb from the request; mem_valid<=1; go to MEM.
  - MEM: hold mem_valid and the mem_* buses stable until mem_ready=1. Then mem_valid<=0 and go to RELEASE.
    - Read: rdata<=mem_rdata. If cache_en=1 and kill=0, write tag, data and vld for the line.
    - Write hit: merge wdata into the line per byte under wstrb. The line stays valid.
    - Write miss: no allocation.
  - RELEASE: wait for mem_ready=0. qqspi drops ready one cycle after valid falls. Then ready<=1 for exactly one cycle and go to IDLE.
- qqspi handshake rules: mem_valid never rises while mem_ready=1, and mem_valid never drops before mem_ready.
- Write hit/miss is evaluated at acceptance, stored in a flag and applied in MEM.
- Writes always go to memory (write-through). Byte alignment is qqspi's job; this block passes wstrb and wdata unchanged.
- flush:
  - Clears all vld bits in the cycle after it is sampled.
  - If a read miss is in MEM or RELEASE when flush arrives, set kill. That fill still returns data upstream but does not allocate. kill clears on return to IDLE.
  - flush coinciding with a read hit in IDLE: the hit is still served from the old data. All lines are invalid afterwards.
- cache_en=0: no hits and no allocation. Write-hit merges are also suppressed, so a stale line is never updated. Software must flush before re-enabling.
- Index conflict: a miss overwrites the line, replacing the old tag.
- Uncached transfer latency equals qqspi latency plus 2 cycles (accept, release).

Decomposition:
- Package qqspi_cache_pkg holds:
  - state localparams IDLE=2'd0, MEM=2'd1, RELEASE=2'd2;
  - ADDR_W=23, DATA_W=32;
  - the byte-merge function (old, new, wstrb) -> merged word.
- Sub-module qqspi_cache_store:
  - contents: tag array, data array and valid-bit vector;
  - read port: asynchronous, indexed;
  - write port: synchronous, one per cycle, with per-byte enables;
  - flush-clear input for the valid bits;
  - reset input clears the valid bits.
- qqspi_rd_cache contains only the FSM, the kill/hit flags and the mem_* registers.

Test Plan:
- Read 0x000010, memory model returns 0xDEADBEEF -> one mem transaction, ready pulse, rdata=0xDEADBEEF. Repeat the read -> ready 1 cycle after valid, mem_valid stays 0.
- Cached 0x000010 = 0xDEADBEEF, write wstrb=4'b0010 wdata=0x0000AA00 -> mem_wstrb=0010 forwarded. Re-read hits with rdata=0xDEADAAEF.
- Write to an uncached 0x000020 -> forwarded. Following read of 0x000020 misses: a mem transaction is issued, confirming no allocation.
- Read 0x000010, then read 0x000018 (same idx, ENTRIES=8) -> second read misses. Re-read of 0x000010 misses again (evicted).
- flush pulsed while a read miss of 0x000030 is in MEM -> data returned upstream. Re-read of 0x000030 misses, and earlier-cached 0x000010 also misses.
- reset asserted while in MEM -> mem_valid and ready are 0 in the same cycle. After release a read of 0x000010 misses.
- Throughout all scenarios, check that mem_valid never rises while mem_ready=1 and never drops before mem_ready.
